// File: rtl/data_memory_pkg.sv
// Shared types and default sizing for the parameterised data memory.
package data_memory_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DEPTH  = 256;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;
endpackage

// File: rtl/sp_ram_be.sv
// Single-port byte-enabled storage with registered read data.
module sp_ram_be
  import data_memory_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic                re,
  input  logic                rz,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   rdata
);
  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;

  // Caller guarantees addr < DEPTH whenever we/re are set.
  assign idx = addr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Only the read register is reset; the array is cleared by the owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[idx];
    else if (rz) rdata <= '0;
  end
endmodule

// File: rtl/param_data_memory.sv
// Data memory that zero-fills itself after reset or clear, then serves
// byte-enabled single-cycle requests with a one-cycle read response.
module param_data_memory
  import data_memory_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);
  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] CNT_LAST  = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              accept, in_range;
  logic              ram_we, ram_re, ram_rz;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [NB-1:0]     ram_be;

  assign in_range = ({1'b0, req_addr} < DEPTH_EXT);
  assign accept   = req_valid && req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (cnt == CNT_LAST) state_nxt = IDLE;
      IDLE:    if (clear)           state_nxt = INIT;
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    busy      = (state == INIT);
    req_ready = (state == IDLE) && !clear;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_rz    = 1'b0;
    ram_addr  = req_addr;
    ram_wdata = req_wdata;
    ram_be    = req_be;
    if (state == INIT) begin
      ram_we    = 1'b1;
      ram_addr  = cnt;
      ram_wdata = '0;
      ram_be    = '1;
    end else if (accept) begin
      ram_we = req_write && in_range;
      ram_re = !req_write && in_range;
      ram_rz = !req_write && !in_range;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == INIT) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= accept && !req_write;
      rsp_err   <= accept && !in_range;
    end
  end

  sp_ram_be #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .re    (ram_re),
    .rz    (ram_rz),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .be    (ram_be),
    .rdata (rsp_rdata)
  );
endmodule

// File: tb/tb_param_data_memory.sv
// Directed bench for param_data_memory: default instance plus a DEPTH=200 instance.
module tb_param_data_memory;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // default instance (DEPTH 256)
  logic        rst = 1'b1, clear = 1'b0, req_valid = 1'b0, req_write = 1'b0;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [7:0]  req_addr = '0;
  logic [15:0] req_wdata = '0, rsp_rdata;
  logic [1:0]  req_be = '0;

  // DEPTH 200 instance
  logic        b_rst = 1'b1, b_clear = 1'b0, b_req_valid = 1'b0, b_req_write = 1'b0;
  logic        b_req_ready, b_rsp_valid, b_rsp_err, b_busy;
  logic [7:0]  b_req_addr = '0;
  logic [15:0] b_req_wdata = '0, b_rsp_rdata;
  logic [1:0]  b_req_be = '0;

  param_data_memory dut (
    .clk(clk), .rst(rst), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  param_data_memory #(.DATA_W(16), .ADDR_W(8), .DEPTH(200)) dut_b (
    .clk(clk), .rst(b_rst), .clear(b_clear), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_write(b_req_write), .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic a_issue(input logic w, input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    @(posedge clk); #1;
  endtask

  task automatic a_idle();
    req_valid = 1'b0; req_write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic b_issue(input logic w, input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
    b_req_valid = 1'b1; b_req_write = w; b_req_addr = a; b_req_wdata = d; b_req_be = be;
    @(posedge clk); #1;
  endtask

  task automatic b_idle();
    b_req_valid = 1'b0; b_req_write = 1'b0;
    @(posedge clk); #1;
  endtask

  // Counts edges until busy drops, bounded; a stuck busy shows up as a wrong count.
  task automatic busy_len(input bit use_b, input string tag, input int exp);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while ((use_b ? b_busy : busy) && n < 1000);
    chk(tag, n, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1);
    chk("rst_ready", req_ready, 0);
    chk("rst_rvalid", rsp_valid, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_rdata", rsp_rdata, 0);

    rst = 1'b0;
    busy_len(0, "init_len", 256);
    chk("ready_after_init", req_ready, 1);

    a_issue(0, 8'h10, 16'h0, 2'b11);
    chk("rd10_valid", rsp_valid, 1);
    chk("rd10_zero", rsp_rdata, 16'h0000);
    chk("rd10_err", rsp_err, 0);

    a_issue(1, 8'h10, 16'hABCD, 2'b11);
    chk("wr_no_rvalid", rsp_valid, 0);
    a_issue(0, 8'h10, 16'h0, 2'b00);
    chk("raw_valid", rsp_valid, 1);
    chk("raw_data", rsp_rdata, 16'hABCD);
    a_idle();
    chk("idle_valid", rsp_valid, 0);
    chk("hold_rdata", rsp_rdata, 16'hABCD);

    a_issue(1, 8'h20, 16'h1234, 2'b11);
    a_issue(1, 8'h20, 16'hFF99, 2'b01);
    a_issue(0, 8'h20, 16'h0, 2'b00);
    chk("be_lo", rsp_rdata, 16'h1299);
    a_issue(1, 8'h20, 16'h56EE, 2'b10);
    a_issue(0, 8'h20, 16'h0, 2'b00);
    chk("be_hi", rsp_rdata, 16'h5699);
    a_issue(1, 8'h20, 16'hFFFF, 2'b00);
    a_issue(0, 8'h20, 16'h0, 2'b00);
    chk("be_none", rsp_rdata, 16'h5699);
    a_issue(0, 8'h10, 16'h0, 2'b00);
    chk("other_word", rsp_rdata, 16'hABCD);
    a_idle();

    // clear colliding with a write: clear wins
    clear = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10; req_wdata = 16'hBEEF; req_be = 2'b11;
    #1;
    chk("clr_ready", req_ready, 0);
    chk("clr_busy_pre", busy, 0);
    @(posedge clk); #1;
    clear = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    chk("clr_busy", busy, 1);
    clear = 1'b1;
    #1;
    chk("clr_ignored_ready", req_ready, 0);
    busy_len(0, "clr_init_len", 256);
    clear = 1'b0;
    a_issue(0, 8'h10, 16'h0, 2'b00);
    chk("clr_rd10", rsp_rdata, 16'h0000);
    a_issue(0, 8'h20, 16'h0, 2'b00);
    chk("clr_rd20", rsp_rdata, 16'h0000);

    // reset with a response in flight
    a_issue(1, 8'h20, 16'h7A7A, 2'b11);
    a_issue(0, 8'h20, 16'h0, 2'b00);
    chk("pre_rst_data", rsp_rdata, 16'h7A7A);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_valid", rsp_valid, 0);
    chk("midrst_rdata", rsp_rdata, 0);
    chk("midrst_busy", busy, 1);
    chk("midrst_ready", req_ready, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    busy_len(0, "rst_traffic_len", 256);

    // reset at INIT counter = 100
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("cnt100_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    busy_len(0, "rst_init_len", 256);
    a_issue(0, 8'h20, 16'h0, 2'b00);
    chk("post_rst_rd", rsp_rdata, 16'h0000);
    a_idle();

    // DEPTH 200 instance: out-of-range handling
    b_rst = 1'b0;
    busy_len(1, "b_init_len", 200);
    b_issue(1, 8'hC7, 16'h5555, 2'b11);
    chk("b_wr_in_err", b_rsp_err, 0);
    b_issue(0, 8'hC7, 16'h0, 2'b00);
    chk("b_rd_c7", b_rsp_rdata, 16'h5555);
    b_issue(1, 8'hC8, 16'h1111, 2'b11);
    chk("b_wr_oor_err", b_rsp_err, 1);
    chk("b_wr_oor_valid", b_rsp_valid, 0);
    b_issue(0, 8'hC8, 16'h0, 2'b00);
    chk("b_rd_oor_err", b_rsp_err, 1);
    chk("b_rd_oor_valid", b_rsp_valid, 1);
    chk("b_rd_oor_data", b_rsp_rdata, 16'h0000);
    b_idle();
    chk("b_err_pulse", b_rsp_err, 0);
    chk("b_hold_zero", b_rsp_rdata, 16'h0000);
    b_issue(1, 8'hFF, 16'h2222, 2'b11);
    chk("b_wr_ff_err", b_rsp_err, 1);
    b_issue(0, 8'hC7, 16'h0, 2'b00);
    chk("b_c7_kept", b_rsp_rdata, 16'h5555);
    chk("b_c7_err", b_rsp_err, 0);
    b_issue(0, 8'h00, 16'h0, 2'b00);
    chk("b_00_kept", b_rsp_rdata, 16'h0000);
    b_issue(0, 8'h48, 16'h0, 2'b00);
    chk("b_48_kept", b_rsp_rdata, 16'h0000);
    b_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
